// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register sitting downstream of the 32x32
//               register file. Captures operands, immediate, PC and decoded
//               control, detects load-use hazards (stall + bubble), supports
//               a synchronous flush and counts stall cycles (saturating).
//               Optional feature macro: WB_BYPASS_EN (writeback bypass into
//               the captured operands).
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int ALUOP_W  = 4,
    parameter int STALL_CW = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    // decode side
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [XLEN-1:0]     i_id_pc,
    input  logic [REG_AW-1:0]   i_id_rs1,
    input  logic [REG_AW-1:0]   i_id_rs2,
    input  logic [REG_AW-1:0]   i_id_rd,
    input  logic [XLEN-1:0]     i_rf_rdata1,
    input  logic [XLEN-1:0]     i_rf_rdata2,
    input  logic [XLEN-1:0]     i_id_imm,
    input  logic [5:0]          i_id_ctrl,
    input  logic [ALUOP_W-1:0]  i_id_aluop,
    // writeback bypass source
    input  logic                i_wb_regwrite,
    input  logic [REG_AW-1:0]   i_wb_rd,
    input  logic [XLEN-1:0]     i_wb_data,
    // branch flush
    input  logic                i_flush,
    // execute side
    output logic                o_ex_valid,
    input  logic                i_ex_ready,
    output logic [XLEN-1:0]     o_ex_pc,
    output logic [XLEN-1:0]     o_ex_imm,
    output logic [XLEN-1:0]     o_ex_op1,
    output logic [XLEN-1:0]     o_ex_op2,
    output logic [REG_AW-1:0]   o_ex_rs1,
    output logic [REG_AW-1:0]   o_ex_rs2,
    output logic [REG_AW-1:0]   o_ex_rd,
    output logic [5:0]          o_ex_ctrl,
    output logic [ALUOP_W-1:0]  o_ex_aluop,
    output logic [STALL_CW-1:0] o_stall_cnt
);

    // Control vector layout: {regWrite, memRead, memWrite, memToReg, aluSrc, branch}
    localparam int c_MEMREAD_BIT = 4;

    logic                r_ex_valid;
    logic [XLEN-1:0]     r_ex_pc;
    logic [XLEN-1:0]     r_ex_imm;
    logic [XLEN-1:0]     r_ex_op1;
    logic [XLEN-1:0]     r_ex_op2;
    logic [REG_AW-1:0]   r_ex_rs1;
    logic [REG_AW-1:0]   r_ex_rs2;
    logic [REG_AW-1:0]   r_ex_rd;
    logic [5:0]          r_ex_ctrl;
    logic [ALUOP_W-1:0]  r_ex_aluop;
    logic [STALL_CW-1:0] r_stall_cnt;

    logic                w_load_use;
    logic                w_advance;
    logic [XLEN-1:0]     w_op1;
    logic [XLEN-1:0]     w_op2;

    // Hazard detection and handshake: a load in EX whose rd feeds decode stalls it
    always_comb begin
        w_load_use = r_ex_valid & r_ex_ctrl[c_MEMREAD_BIT] & (r_ex_rd != '0) & i_in_valid &
                     ((i_id_rs1 == r_ex_rd) | (i_id_rs2 == r_ex_rd));
        w_advance  = ~r_ex_valid | i_ex_ready;
        o_in_ready = w_advance & ~w_load_use;
    end

`ifdef WB_BYPASS_EN
    // Operand select: x0 reads as zero, otherwise a same-cycle writeback wins over the regfile
    always_comb begin
        if (i_id_rs1 == '0)
            w_op1 = '0;
        else if (i_wb_regwrite && (i_wb_rd == i_id_rs1))
            w_op1 = i_wb_data;
        else
            w_op1 = i_rf_rdata1;

        if (i_id_rs2 == '0)
            w_op2 = '0;
        else if (i_wb_regwrite && (i_wb_rd == i_id_rs2))
            w_op2 = i_wb_data;
        else
            w_op2 = i_rf_rdata2;
    end
`else
    // Writeback ports are present for interface compatibility but have no effect here
    logic w_unused_wb;
    assign w_unused_wb = ^{i_wb_regwrite, i_wb_rd, i_wb_data};

    // Operand select: the regfile does not guard x0, so force it to zero here
    always_comb begin
        w_op1 = (i_id_rs1 == '0) ? '0 : i_rf_rdata1;
        w_op2 = (i_id_rs2 == '0) ? '0 : i_rf_rdata2;
    end
`endif

    // EX-side register: flush beats bubble beats capture; hold when EX is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid <= 1'b0;
            r_ex_pc    <= '0;
            r_ex_imm   <= '0;
            r_ex_op1   <= '0;
            r_ex_op2   <= '0;
            r_ex_rs1   <= '0;
            r_ex_rs2   <= '0;
            r_ex_rd    <= '0;
            r_ex_ctrl  <= '0;
            r_ex_aluop <= '0;
        end else if (i_flush) begin
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= '0;
        end else if (w_advance) begin
            if (w_load_use) begin
                r_ex_valid <= 1'b0;
                r_ex_ctrl  <= '0;
            end else if (i_in_valid) begin
                r_ex_valid <= 1'b1;
                r_ex_pc    <= i_id_pc;
                r_ex_imm   <= i_id_imm;
                r_ex_op1   <= w_op1;
                r_ex_op2   <= w_op2;
                r_ex_rs1   <= i_id_rs1;
                r_ex_rs2   <= i_id_rs2;
                r_ex_rd    <= i_id_rd;
                r_ex_ctrl  <= i_id_ctrl;
                r_ex_aluop <= i_id_aluop;
            end else begin
                r_ex_valid <= 1'b0;
            end
        end
    end

    // Stall counter: one per hazard cycle not cancelled by a flush, sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (w_load_use && !i_flush && !(&r_stall_cnt))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign o_ex_valid  = r_ex_valid;
    assign o_ex_pc     = r_ex_pc;
    assign o_ex_imm    = r_ex_imm;
    assign o_ex_op1    = r_ex_op1;
    assign o_ex_op2    = r_ex_op2;
    assign o_ex_rs1    = r_ex_rs1;
    assign o_ex_rs2    = r_ex_rs2;
    assign o_ex_rd     = r_ex_rd;
    assign o_ex_ctrl   = r_ex_ctrl;
    assign o_ex_aluop  = r_ex_aluop;
    assign o_stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage. A transaction-level
//               reference model tracks the EX-side contents and the stall
//               count; directed scenarios and random traffic are compared
//               against it. Honors WB_BYPASS_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int VW = 171;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] id_pc, rf_rdata1, rf_rdata2, id_imm, wb_data;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic [5:0]  id_ctrl;
    logic [3:0]  id_aluop;
    logic        wb_regwrite, flush, ex_ready;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_imm, ex_op1, ex_op2;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [5:0]  ex_ctrl;
    logic [3:0]  ex_aluop;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_id_pc(id_pc), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rd(id_rd),
        .i_rf_rdata1(rf_rdata1), .i_rf_rdata2(rf_rdata2), .i_id_imm(id_imm),
        .i_id_ctrl(id_ctrl), .i_id_aluop(id_aluop),
        .i_wb_regwrite(wb_regwrite), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
        .i_flush(flush),
        .o_ex_valid(ex_valid), .i_ex_ready(ex_ready),
        .o_ex_pc(ex_pc), .o_ex_imm(ex_imm), .o_ex_op1(ex_op1), .o_ex_op2(ex_op2),
        .o_ex_rs1(ex_rs1), .o_ex_rs2(ex_rs2), .o_ex_rd(ex_rd),
        .o_ex_ctrl(ex_ctrl), .o_ex_aluop(ex_aluop), .o_stall_cnt(stall_cnt)
    );

    logic [VW-1:0] dut_vec;
    assign dut_vec = {ex_valid, ex_pc, ex_imm, ex_op1, ex_op2, ex_rs1, ex_rs2, ex_rd,
                      ex_ctrl, ex_aluop, stall_cnt, in_ready};

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        v;
        logic [31:0] pc, imm, op1, op2;
        logic [4:0]  rs1, rs2, rd;
        logic [5:0]  ctrl;
        logic [3:0]  aluop;
    } ex_t;

    ex_t m;
    int  m_stall;

    function automatic logic m_load_use();
        return m.v && m.ctrl[4] && (m.rd != 0) && in_valid &&
               ((id_rs1 == m.rd) || (id_rs2 == m.rd));
    endfunction

    function automatic logic [31:0] m_operand(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (wb_regwrite && wb_rd == idx) return wb_data;
`endif
        return rf;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic rdy;
        rdy = (!m.v || ex_ready) && !m_load_use();
        return {m.v, m.pc, m.imm, m.op1, m.op2, m.rs1, m.rs2, m.rd, m.ctrl, m.aluop,
                m_stall[15:0], rdy};
    endfunction

    task automatic model_update();
        logic lu, adv;
        lu  = m_load_use();
        adv = !m.v || ex_ready;
        if (lu && !flush && m_stall < 65535) m_stall++;
        if (flush) begin
            m.v = 0; m.ctrl = 0;
        end else if (adv && lu) begin
            m.v = 0; m.ctrl = 0;
        end else if (adv && in_valid) begin
            m.v = 1; m.pc = id_pc; m.imm = id_imm;
            m.op1 = m_operand(id_rs1, rf_rdata1);
            m.op2 = m_operand(id_rs2, rf_rdata2);
            m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
            m.ctrl = id_ctrl; m.aluop = id_aluop;
        end else if (adv) begin
            m.v = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic [5:0] ctrl);
        in_valid  = 1'b1;
        id_pc     = pc;
        id_rs1    = rs1;
        id_rs2    = rs2;
        id_rd     = rd;
        id_ctrl   = ctrl;
        id_aluop  = pc[3:0];
        id_imm    = pc ^ 32'h0F0F_0000;
        rf_rdata1 = $urandom;
        rf_rdata2 = $urandom;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m = '0; m_stall = 0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        // power-on: everything zero while reset held
        #2;
        checks++;
        if (dut_vec !== exp_vec() || ex_valid !== 1'b0) begin
            errors++; $display("FAIL reset_por got=%h exp=%h", dut_vec, exp_vec());
        end
        @(negedge clk); rst_n = 1'b1;
        // capture something, then assert reset mid-cycle
        ex_ready = 1'b1;
        set_instr(32'h40, 5'd1, 5'd2, 5'd3, 6'b100000);
        step();
        checks++;
        if (ex_valid !== 1'b1) begin
            errors++; $display("FAIL reset_pre_accept got=%b exp=1", ex_valid);
        end
        #3;
        rst_n = 1'b0;
        m = '0; m_stall = 0;
        #1;
        checks++;
        if (dut_vec !== exp_vec() || ex_pc !== 32'd0 || stall_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_async got=%h exp=%h", dut_vec, exp_vec());
        end
        in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_streaming();
        logic [31:0] r1, r2;
        do_reset();
        ex_ready = 1'b1; wb_regwrite = 1'b0; flush = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            set_instr(32'h100 + 32'(4 * i), 5'(10 + i), 5'(20 + i), 5'(i), 6'b100000);
            r1 = rf_rdata1; r2 = rf_rdata2;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready);
            end
            step();
            checks++;
            if (dut_vec !== exp_vec() || ex_valid !== 1'b1 || ex_op1 !== r1 ||
                ex_op2 !== r2 || ex_rd !== 5'(i)) begin
                errors++; $display("FAIL stream_capture[%0d] got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_load_use();
        do_reset();
        ex_ready = 1'b1; flush = 1'b0; wb_regwrite = 1'b0;
        set_instr(32'h200, 5'd1, 5'd2, 5'd5, 6'b110100);   // lw x5
        step();
        set_instr(32'h204, 5'd5, 5'd3, 5'd6, 6'b100000);   // add x6, x5, x3
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL loaduse_in_ready got=%b exp=0", in_ready);
        end
        step();
        checks++;
        if (dut_vec !== exp_vec() || ex_valid !== 1'b0 || ex_ctrl !== 6'd0 || stall_cnt !== 16'd1) begin
            errors++; $display("FAIL loaduse_bubble got=%h exp=%h", dut_vec, exp_vec());
        end
        step();
        checks++;
        if (dut_vec !== exp_vec() || ex_valid !== 1'b1 || ex_rs1 !== 5'd5 ||
            ex_rd !== 5'd6 || stall_cnt !== 16'd1) begin
            errors++; $display("FAIL loaduse_capture got=%h exp=%h", dut_vec, exp_vec());
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_flush();
        ex_ready = 1'b1;
        set_instr(32'h300, 5'd1, 5'd2, 5'd3, 6'b100001);
        step();
        set_instr(32'h380, 5'd4, 5'd5, 5'd6, 6'b100000);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (dut_vec !== exp_vec() || ex_valid !== 1'b0 || ex_ctrl !== 6'd0 || ex_pc !== 32'h300) begin
            errors++; $display("FAIL flush got=%h exp=%h", dut_vec, exp_vec());
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure_x0();
        logic [VW-1:0] snap;
        ex_ready = 1'b1;
        set_instr(32'h400, 5'd0, 5'd9, 5'd8, 6'b100010);
        rf_rdata1 = 32'hDEAD_BEEF;
        step();
        checks++;
        if (dut_vec !== exp_vec() || ex_op1 !== 32'd0) begin
            errors++; $display("FAIL x0_operand got=%h exp=0", ex_op1);
        end
        snap = dut_vec;
        ex_ready = 1'b0;
        set_instr(32'h404, 5'd11, 5'd12, 5'd13, 6'b100000);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready);
            end
            step();
            checks++;
            if (dut_vec !== exp_vec() || dut_vec[VW-1:1] !== snap[VW-1:1]) begin
                errors++; $display("FAIL bp_hold[%0d] got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        ex_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_bypass();
        logic [31:0] want;
        ex_ready = 1'b1;
        set_instr(32'h500, 5'd1, 5'd7, 5'd2, 6'b100000);
        rf_rdata2 = 32'd0;
        wb_regwrite = 1'b1; wb_rd = 5'd7; wb_data = 32'h1234;
`ifdef WB_BYPASS_EN
        want = 32'h1234;
`else
        want = 32'h0;
`endif
        step();
        checks++;
        if (dut_vec !== exp_vec() || ex_op2 !== want) begin
            errors++; $display("FAIL bypass_op2 got=%h exp=%h", ex_op2, want);
        end
        wb_regwrite = 1'b0; in_valid = 1'b0;
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid    = ($urandom % 4) != 0;
            ex_ready    = ($urandom % 4) != 0;
            flush       = ($urandom % 16) == 0;
            id_pc       = $urandom;
            id_imm      = $urandom;
            rf_rdata1   = $urandom;
            rf_rdata2   = $urandom;
            id_rs1      = 5'($urandom % 8);
            id_rs2      = 5'($urandom % 8);
            id_rd       = 5'($urandom % 8);
            id_ctrl     = 6'($urandom);
            id_aluop    = 4'($urandom);
            wb_regwrite = 1'($urandom);
            wb_rd       = 5'($urandom % 8);
            wb_data     = $urandom;
            step();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL random[%0d] got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        flush = 1'b0; in_valid = 1'b0; wb_regwrite = 1'b0; ex_ready = 1'b1;
        step();
    endtask

    task automatic test_saturation();
        do_reset();
        ex_ready = 1'b1; flush = 1'b0; wb_regwrite = 1'b0;
        set_instr(32'h600, 5'd1, 5'd2, 5'd5, 6'b110100);   // lw x5
        step();
        ex_ready = 1'b0;
        set_instr(32'h604, 5'd5, 5'd5, 5'd6, 6'b100000);   // dependent, held forever
        for (int i = 0; i < 65536 + 3; i++) step();
        checks++;
        if (dut_vec !== exp_vec() || stall_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL stall_saturate got=%h exp=ffff", stall_cnt);
        end
        in_valid = 1'b0; ex_ready = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; ex_ready = 1'b0; flush = 1'b0;
        id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        rf_rdata1 = '0; rf_rdata2 = '0; id_imm = '0; id_ctrl = '0; id_aluop = '0;
        wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
        m = '0; m_stall = 0;

        test_reset();
        test_streaming();
        test_load_use();
        test_flush();
        test_backpressure_x0();
        test_bypass();
        test_random();
        test_saturation();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
